// File: rtl/matrix_arb_requester.sv
// rtl/matrix_arb_requester.sv - per-channel job queues feeding a matrix arbiter
// Raises req for every non-empty queue and issues the granted head one cycle after a legal grant.
module matrix_arb_requester #(
    parameter int N     = 3,
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int CW   = (N > 1) ? $clog2(N) : 1,
    localparam int PW   = $clog2(DEPTH),
    localparam int CNTW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    input  logic [CW-1:0] push_ch,
    input  logic [W-1:0]  push_data,
    output logic          push_ready,
    output logic [N-1:0]  req,
    input  logic [N-1:0]  gnt,
    input  logic          valid_gnt,
    output logic          out_valid,
    output logic [CW-1:0] out_ch,
    output logic [W-1:0]  out_data,
    output logic          err_gnt
);

    logic [W-1:0]    mem    [N][DEPTH];
    logic [PW-1:0]   rd_ptr [N];
    logic [PW-1:0]   wr_ptr [N];
    logic [CNTW-1:0] count  [N];

    logic          ch_ok;
    logic          gnt_onehot;
    logic [CW-1:0] gnt_idx;
    logic          pop_go;
    logic          push_go;
    logic [N-1:0]  pop_sel;
    logic [N-1:0]  push_sel;

    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = (count[i] != '0);
        end
    end

    always_comb begin
        ch_ok      = (int'(push_ch) < N);
        push_ready = 1'b0;
        if (ch_ok) begin
            push_ready = (count[push_ch] != CNTW'(DEPTH));
        end

        gnt_onehot = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
        gnt_idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = CW'(i);
            end
        end
        pop_go  = valid_gnt && gnt_onehot && ((gnt & req) != '0);
        pop_sel = pop_go ? gnt : '0;

        // A full queue still accepts a push when its head leaves in the same cycle.
        push_go  = push_valid && ch_ok && (push_ready || pop_sel[push_ch]);
        push_sel = '0;
        if (push_go) begin
            push_sel[push_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_go) begin
            mem[push_ch][wr_ptr[push_ch]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            err_gnt   <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push_sel[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop_sel[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                case ({push_sel[i], pop_sel[i]})
                    2'b10:   count[i] <= count[i] + CNTW'(1);
                    2'b01:   count[i] <= count[i] - CNTW'(1);
                    default: count[i] <= count[i];
                endcase
            end
            out_valid <= pop_go;
            err_gnt   <= valid_gnt && !pop_go;
            if (pop_go) begin
                out_ch   <= gnt_idx;
                out_data <= mem[gnt_idx][rd_ptr[gnt_idx]];
            end
        end
    end

endmodule

// File: tb/tb_matrix_arb_requester.sv
// tb/tb_matrix_arb_requester.sv - directed and random checks against a queue-based reference model
module tb_matrix_arb_requester;

    logic       clk;
    logic       rst;
    logic       push_valid;
    logic [1:0] push_ch;
    logic [7:0] push_data;
    logic       push_ready;
    logic [2:0] req;
    logic [2:0] gnt;
    logic       valid_gnt;
    logic       out_valid;
    logic [1:0] out_ch;
    logic [7:0] out_data;
    logic       err_gnt;

    int tests;
    int fails;

    logic [7:0] mq [3][$];
    logic [1:0] m_ch;
    logic [7:0] m_data;

    matrix_arb_requester #(.N(3), .DEPTH(4), .W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ch    (push_ch),
        .push_data  (push_data),
        .push_ready (push_ready),
        .req        (req),
        .gnt        (gnt),
        .valid_gnt  (valid_gnt),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .err_gnt    (err_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_req();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (mq[i].size() != 0);
        return r;
    endfunction

    task automatic cycle(input logic pv, input logic [1:0] pch, input logic [7:0] pd,
                         input logic vg, input logic [2:0] g);
        bit   legal;
        int   k;
        bit   do_push;
        logic exp_valid;
        logic exp_err;
        @(negedge clk);
        push_valid = pv;
        push_ch    = pch;
        push_data  = pd;
        valid_gnt  = vg;
        gnt        = g;
        #1;
        check("push_ready", 32'(push_ready), 32'((pch < 3) && (mq[pch].size() < 4)));
        check("req_pre", 32'(req), 32'(model_req()));

        k = 0;
        for (int i = 0; i < 3; i++) if (g[i]) k = i;
        legal     = vg && ($countones(g) == 1) && (mq[k].size() != 0);
        do_push   = pv && (pch < 3) && ((mq[pch].size() < 4) || (legal && k == int'(pch)));
        exp_valid = legal;
        exp_err   = vg && !legal;
        if (legal) begin
            m_ch   = 2'(k);
            m_data = mq[k].pop_front();
        end
        if (do_push) mq[pch].push_back(pd);

        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("err_gnt", 32'(err_gnt), 32'(exp_err));
        check("out_ch", 32'(out_ch), 32'(m_ch));
        check("out_data", 32'(out_data), 32'(m_data));
        check("req_post", 32'(req), 32'(model_req()));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        push_valid = 1'b0;
        valid_gnt  = 1'b0;
        gnt        = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_req", 32'(req), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_err", 32'(err_gnt), 32'h0);
        check("rst_out_ch", 32'(out_ch), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_ch   = '0;
        m_data = '0;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        m_ch       = '0;
        m_data     = '0;
        rst        = 1'b1;
        push_valid = 1'b0;
        push_ch    = '0;
        push_data  = '0;
        valid_gnt  = 1'b0;
        gnt        = '0;
        #1;
        check("init_req", 32'(req), 32'h0);
        check("init_out_valid", 32'(out_valid), 32'h0);
        check("init_err", 32'(err_gnt), 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        // single push then legal grant
        cycle(1, 2'd0, 8'hA1, 0, 3'b000);
        cycle(0, 2'd0, 8'h00, 1, 3'b001);

        // fill ch2, overflow drop, drain in order
        for (int i = 0; i < 5; i++) cycle(1, 2'd2, 8'h20 + 8'(i), 0, 3'b000);
        for (int i = 0; i < 4; i++) cycle(0, 2'd0, 8'h00, 1, 3'b100);

        // full ch1 with simultaneous push and pop
        for (int i = 0; i < 4; i++) cycle(1, 2'd1, 8'h10 + 8'(i), 0, 3'b000);
        cycle(1, 2'd1, 8'h1F, 1, 3'b010);
        cycle(1, 2'd1, 8'hEE, 0, 3'b000);

        // illegal grants: multi-hot, empty channel, zero
        cycle(0, 2'd0, 8'h00, 1, 3'b011);
        cycle(0, 2'd0, 8'h00, 1, 3'b100);
        cycle(0, 2'd0, 8'h00, 1, 3'b000);

        // gnt ignored without valid_gnt
        cycle(1, 2'd0, 8'h01, 0, 3'b000);
        cycle(1, 2'd2, 8'h02, 0, 3'b000);
        cycle(0, 2'd0, 8'h00, 0, 3'b111);
        cycle(1, 2'd3, 8'h33, 0, 3'b000);

        // mid-operation reset discards queues
        reset_pulse();
        cycle(1, 2'd0, 8'h51, 0, 3'b000);
        cycle(1, 2'd0, 8'h52, 0, 3'b000);
        cycle(1, 2'd1, 8'h53, 0, 3'b000);
        reset_pulse();
        cycle(0, 2'd0, 8'h00, 1, 3'b001);
        cycle(0, 2'd0, 8'h00, 1, 3'b010);
        cycle(1, 2'd1, 8'h60, 0, 3'b000);
        cycle(0, 2'd0, 8'h00, 1, 3'b010);

        // randomized traffic, grants biased toward one-hot
        for (int n = 0; n < 400; n++) begin
            logic [2:0] g;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 7) g = 3'b001 << $urandom_range(0, 2);
            else         g = 3'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_arb_requester.md
MATRIX_ARB_REQUESTER -- requirements
Module: matrix_arb_requester

Interface
REQ-001 The block SHALL have parameter N, default 3, the number of requesting channels and the width of req/gnt.
REQ-002 The block SHALL have parameter DEPTH, default 4, the per-channel job queue depth (power of 2, at least 2).
REQ-003 The block SHALL have parameter W, default 8, the job payload width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high (clk; rst).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 push_valid  input  1  job offered this cycle.
REQ-008 push_ch  input  $clog2(N)  target channel of offered job.
REQ-009 push_data  input  W  job payload.
REQ-010 push_ready  output  1  queue of push_ch not full (combinational from state and push_ch).
REQ-011 req  output  N  request vector to matrix arbiter; bit i = channel i queue non-empty.
REQ-012 gnt  input  N  grant vector from arbiter.
REQ-013 valid_gnt  input  1  gnt is valid this cycle.
REQ-014 out_valid  output  1  registered one-cycle pulse: a granted job issued.
REQ-015 out_ch  output  $clog2(N)  channel of issued job.
REQ-016 out_data  output  W  payload of issued job.
REQ-017 err_gnt  output  1  registered one-cycle pulse: illegal grant seen.

Function
REQ-018 Each channel SHALL own an independent FIFO of DEPTH entries with a read pointer, a write pointer and a count register of width $clog2(DEPTH)+1.
REQ-019 A push SHALL occur on a rising edge when push_valid=1, push_ready=1 and push_ch<N; the job is written at that channel's write pointer.
REQ-020 When push_valid=1 and the channel is full, or push_ch>=N, the job SHALL be dropped with no state change and no error.
REQ-021 req[i] SHALL equal (count[i]!=0), decoded combinationally from registered counts, so it rises one cycle after the first push.
REQ-022 A grant SHALL be legal when valid_gnt=1, gnt is exactly one-hot, and req[k]=1 for the set bit k.
REQ-023 On a legal grant, channel k SHALL pop its head entry.
REQ-024 On the next cycle after a legal grant: out_valid=1, out_ch=k, out_data=popped payload (latency 1).
REQ-025 When valid_gnt=1 and the grant is illegal (zero, multi-hot, or granting an empty channel): err_gnt=1 next cycle, no pop, out_valid=0.
REQ-026 valid_gnt=0 SHALL ignore gnt entirely; out_valid and err_gnt return to 0 next cycle.
REQ-027 A simultaneous push and legal pop on the same channel SHALL both take effect, leaving count unchanged; this is permitted even when full, with push_ready staying 0 for that cycle.
REQ-028 A pop that empties a channel SHALL drop req[k] on the following cycle; if a push to k occurs in the same cycle, req[k] stays 1.
REQ-029 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow below 0.
REQ-030 out_ch and out_data SHALL hold their last issued values while out_valid=0.

Reset
REQ-031 While rst=1, regardless of clk: all counts and pointers=0, req=0, out_valid=0, out_ch=0, out_data=0, err_gnt=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued jobs; FIFO storage contents need not be cleared.
REQ-033 After rst falls, the first push SHALL be accepted on the first rising edge.

Verification
REQ-034 Push A1 to ch0, then legal gnt=001 with valid_gnt -> req=001 one cycle after push; out_valid=1, out_ch=0, out_data=A1 one cycle after gnt; req=000.
REQ-035 Push 4 jobs to ch2, then a 5th -> push_ready=0, 5th dropped; four grants 100 -> out_data in push order, req[2] falls after the 4th grant.
REQ-036 Full ch1 with simultaneous push and gnt=010 -> head issued, new job appended, count stays 4.
REQ-037 valid_gnt=1 with gnt=011, then gnt=100 with ch2 empty -> err_gnt pulses each time, no pop, out_valid=0.
REQ-038 Queues ch0=2, ch1=1, then rst pulse for 3ns between edges -> req=000 and out_valid=0 immediately; post-reset grants give err_gnt.
REQ-039 valid_gnt=0 with gnt=111 while all channels are queued -> no pop, no err_gnt, counts unchanged.
